// File: rtl/mem_arbiter_if.sv
// Signal bundle for mem_arbiter: instruction-fetch port, data port and the
// single-ported memory side. The arbiter uses the slave view.
interface mem_arbiter_if #(
  parameter int AW = 12
);
  // instruction-fetch port
  logic          if_req;
  logic [31:0]   if_addr;
  logic          if_ack;
  logic          if_err;
  logic [31:0]   if_rdata;

  // data port
  logic          d_req;
  logic          d_we;
  logic [31:0]   d_addr;
  logic [31:0]   d_wdata;
  logic [3:0]    d_wstrb;
  logic          d_ack;
  logic          d_err;
  logic [31:0]   d_rdata;

  // memory side
  logic          mem_en;
  logic [3:0]    mem_we;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [31:0]   mem_rdata;

  logic          busy;

  modport slave (
    input  if_req, if_addr,
    output if_ack, if_err, if_rdata,
    input  d_req, d_we, d_addr, d_wdata, d_wstrb,
    output d_ack, d_err, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output busy
  );

  modport master (
    output if_req, if_addr,
    input  if_ack, if_err, if_rdata,
    output d_req, d_we, d_addr, d_wdata, d_wstrb,
    input  d_ack, d_err, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  busy
  );
endinterface

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one synchronous single-ported memory between an
// instruction-fetch port and a load/store data port.
module mem_arbiter #(
  parameter int MEM_WORDS = 2056,
  parameter int AW        = 12
) (
  input  logic         clk,
  input  logic         reset,
  mem_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP,
    ERR
  } state_t;

  typedef enum logic {
    GNT_IF,
    GNT_D
  } port_t;

  state_t      state_q;
  state_t      state_d;
  port_t       gnt_q;
  port_t       last_q;
  port_t       sel;
  logic        we_q;
  logic        pend_if;
  logic        pend_d;
  logic        grant;
  logic        addr_ok;
  logic [31:0] sel_addr;

  // Arbitration also runs in RESP/ERR so the other port can be granted in the
  // acking cycle; the port being acked is masked since its req is still high.
  always_comb begin
    pend_if = 1'b0;
    pend_d  = 1'b0;
    if (state_q == IDLE) begin
      pend_if = bus.if_req;
      pend_d  = bus.d_req;
    end else if (state_q == RESP || state_q == ERR) begin
      pend_if = bus.if_req && (gnt_q != GNT_IF);
      pend_d  = bus.d_req  && (gnt_q != GNT_D);
    end

    grant = pend_if || pend_d;
    if (pend_if && pend_d) begin
      sel = (last_q == GNT_IF) ? GNT_D : GNT_IF;
    end else if (pend_d) begin
      sel = GNT_D;
    end else begin
      sel = GNT_IF;
    end

    sel_addr = (sel == GNT_D) ? bus.d_addr : bus.if_addr;
    addr_ok  = (sel_addr[1:0] == 2'b00) && (sel_addr[31:2] < 30'(MEM_WORDS));
  end

  always_comb begin
    state_d      = state_q;
    bus.if_ack   = 1'b0;
    bus.if_err   = 1'b0;
    bus.if_rdata = '0;
    bus.d_ack    = 1'b0;
    bus.d_err    = 1'b0;
    bus.d_rdata  = '0;
    bus.busy     = (state_q != IDLE);

    case (state_q)
      ACCESS: state_d = RESP;
      default: begin
        if (grant) begin
          state_d = addr_ok ? ACCESS : ERR;
        end else begin
          state_d = IDLE;
        end
      end
    endcase

    case (state_q)
      RESP: begin
        if (gnt_q == GNT_IF) begin
          bus.if_ack   = 1'b1;
          bus.if_rdata = bus.mem_rdata;
        end else begin
          bus.d_ack   = 1'b1;
          bus.d_rdata = we_q ? '0 : bus.mem_rdata;
        end
      end
      ERR: begin
        if (gnt_q == GNT_IF) begin
          bus.if_ack = 1'b1;
          bus.if_err = 1'b1;
        end else begin
          bus.d_ack = 1'b1;
          bus.d_err = 1'b1;
        end
      end
      default: ;
    endcase
  end

  // Everything the access needs is captured at grant so the requester may
  // change its inputs afterwards; mem_en/mem_we are single-cycle strobes.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      gnt_q         <= GNT_IF;
      last_q        <= GNT_D;
      we_q          <= 1'b0;
      bus.mem_en    <= 1'b0;
      bus.mem_we    <= '0;
      bus.mem_addr  <= '0;
      bus.mem_wdata <= '0;
    end else begin
      state_q    <= state_d;
      bus.mem_en <= 1'b0;
      bus.mem_we <= '0;
      if (grant) begin
        gnt_q  <= sel;
        last_q <= sel;
        we_q   <= (sel == GNT_D) && bus.d_we;
      end
      if (grant && addr_ok) begin
        bus.mem_en   <= 1'b1;
        bus.mem_addr <= sel_addr[AW+1:2];
        if (sel == GNT_D) begin
          bus.mem_we    <= bus.d_we ? bus.d_wstrb : '0;
          bus.mem_wdata <= bus.d_wdata;
        end else begin
          bus.mem_wdata <= '0;
        end
      end
    end
  end

`ifndef SYNTHESIS
  a_single_ack: assert property (@(posedge clk) disable iff (!reset)
    !(bus.if_ack && bus.d_ack));
  a_we_needs_en: assert property (@(posedge clk) disable iff (!reset)
    (bus.mem_we != 4'b0000) |-> bus.mem_en);
  a_en_in_access: assert property (@(posedge clk) disable iff (!reset)
    bus.mem_en |-> (state_q == ACCESS));
`endif

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter MEM_WORDS, default 2056, number of 32-bit words in the shared program/data memory.
REQ-002 SHALL have parameter AW, default 12, word-address width to memory (2^AW >= MEM_WORDS).
REQ-003 SHALL have one clock and one reset: clk is the single clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 if_req  input  1  instruction-fetch request, held until if_ack.
REQ-007 if_addr  input  32  fetch byte address, stable while if_req high.
REQ-008 if_ack  output  1  one-cycle fetch completion pulse.
REQ-009 if_err  output  1  fetch error flag, valid only with if_ack.
REQ-010 if_rdata  output  32  fetched word, valid only with if_ack.
REQ-011 d_req  input  1  data request, held until d_ack.
REQ-012 d_we  input  1  1 = store, 0 = load.
REQ-013 d_addr  input  32  data byte address, stable while d_req high.
REQ-014 d_wdata  input  32  store data.
REQ-015 d_wstrb  input  4  store byte enables; bit i covers bits 8i+7:8i.
REQ-016 d_ack  output  1  one-cycle data completion pulse.
REQ-017 d_err  output  1  data error flag, valid only with d_ack.
REQ-018 d_rdata  output  32  load word, valid only with d_ack.
REQ-019 mem_en  output  1  memory access strobe, registered.
REQ-020 mem_we  output  4  memory byte write enables, registered; nonzero only with mem_en.
REQ-021 mem_addr  output  AW  word address (byte address bits AW+1:2), registered.
REQ-022 mem_wdata  output  32  memory write data, registered.
REQ-023 mem_rdata  input  32  memory read data, valid one cycle after mem_en with mem_we=0.
REQ-024 busy  output  1  high in any state other than IDLE.

Function
REQ-025 SHALL implement FSM states IDLE, ACCESS, RESP, ERR.
REQ-026 IDLE: no request -> IDLE; granted request with valid address -> ACCESS; granted request with invalid address -> ERR.
REQ-027 Address invalid when addr[1:0] != 0 or addr[31:2] >= MEM_WORDS; invalid requests SHALL never assert mem_en.
REQ-028 ACCESS lasts exactly one cycle with mem_en=1, mem_addr, mem_we = (d_we ? d_wstrb : 0) for data grants, 0 for fetch grants; next state RESP.
REQ-029 RESP lasts one cycle: granted port ack=1, err=0, rdata = mem_rdata for reads, 0 for stores.
REQ-030 ERR lasts one cycle: granted port ack=1, err=1, rdata=0.
REQ-031 Latency: request sampled at edge ending cycle N -> ack in cycle N+2 (valid) or N+1 (invalid).
REQ-032 From RESP or ERR, arbitration SHALL run again in that same cycle, excluding the just-acked port; other port pending -> ACCESS/ERR directly, else IDLE.
REQ-033 Both pending in IDLE: grant the port NOT granted last (round-robin); last-grant pointer updates on every grant.
REQ-034 Grant, address, write data and strobes SHALL be latched at grant; requester changes after grant SHALL not affect the access.
REQ-035 Ack outputs SHALL never be asserted for both ports in the same cycle; acks SHALL be zero outside RESP/ERR.
REQ-036 A store with d_wstrb=0 SHALL complete normally (ACCESS with mem_we=0, ack in RESP).

Reset
REQ-037 reset low SHALL immediately force IDLE, last-grant pointer = data (so fetch wins first tie), and all outputs (acks, errs, rdata, mem_en, mem_we, mem_addr, mem_wdata, busy) to 0.
REQ-038 Reset during ACCESS or RESP SHALL abort the access with no ack; mem_en deasserts asynchronously.

Verification
REQ-039 Fetch if_addr=0x0000_0010, mem word 4 = 0x0000_0513 -> mem_en/mem_addr=4 in N+1, if_ack=1, if_rdata=0x0000_0513 in N+2.
REQ-040 Store d_addr=0x20, d_wdata=0xDEADBEEF, d_wstrb=0x3 -> mem_we=0x3, mem_addr=8 in N+1; d_ack in N+2; readback 0x????BEEF with upper bytes unchanged.
REQ-041 if_req and d_req both held from reset release, valid addresses -> grant order fetch, data, fetch, data; acks every other... every 2 cycles, never simultaneous.
REQ-042 d_addr=0x2022 (misaligned) and d_addr=0x2020 (word 2056, out of range) -> d_ack and d_err in N+1, d_rdata=0, mem_en never asserted.
REQ-043 reset asserted in the ACCESS cycle of a fetch -> all outputs 0 immediately, no if_ack; after release, held if_req completes in 2 cycles.
REQ-044 d_addr changed to 0x40 in the ACCESS cycle of a load from 0x30 -> mem_addr stays 12, d_rdata = word 12.
